// File: rtl/regfile_write_queue.sv
// Buffered write port driver for the 32x64 register file: a FIFO of writeback requests feeding a registered rf_ld/rf_sel/rf_data stage.
// Optional combinational read-bypass of pending writes is enabled by defining REGWB_BYPASS_EN.
module regfile_write_queue #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_data,
  input  logic                     rf_stall,
  output logic                     rf_ld,
  output logic [ADDR_W-1:0]        rf_sel,
  output logic [DATA_W-1:0]        rf_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
`ifdef REGWB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]        byp_sel,
  output logic                     byp_hit,
  output logic [DATA_W-1:0]        byp_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(ZERO_REG);

  logic [ADDR_W-1:0] mem_addr_reg [DEPTH];
  logic [DATA_W-1:0] mem_data_reg [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              rf_ld_reg;
  logic [ADDR_W-1:0] rf_sel_reg;
  logic [DATA_W-1:0] rf_data_reg;

  logic accept;
  logic push;
  logic pop;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign req_ready = !full && !rst;

  // Writes to the zero register complete the handshake but never occupy a slot.
  assign accept = req_valid && req_ready;
  assign push   = accept && (req_addr != ZERO_SEL);
  assign pop    = !empty && !rf_stall;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
  end

  // Storage carries no reset; occupancy is tracked solely by count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_reg[wr_ptr_reg] <= req_addr;
      mem_data_reg[wr_ptr_reg] <= req_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rf_ld_reg   <= 1'b0;
      rf_sel_reg  <= '0;
      rf_data_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      rf_ld_reg  <= pop;
      if (pop) begin
        rf_sel_reg  <= mem_addr_reg[rd_ptr_reg];
        rf_data_reg <= mem_data_reg[rd_ptr_reg];
      end
    end
  end

  assign rf_ld   = rf_ld_reg;
  assign rf_sel  = rf_sel_reg;
  assign rf_data = rf_data_reg;
  assign count   = count_reg;

`ifdef REGWB_BYPASS_EN
  logic [DEPTH-1:0]  slot_hit;
  logic [DATA_W-1:0] slot_data [DEPTH];
  logic              byp_hit_c;
  logic [DATA_W-1:0] byp_data_c;

  // Slot gi is the gi-th oldest queued entry; higher gi means younger.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] slot_idx;
      assign slot_idx      = rd_ptr_reg + PTR_W'(gi);
      assign slot_hit[gi]  = (CNT_W'(gi) < count_reg) && (mem_addr_reg[slot_idx] == byp_sel);
      assign slot_data[gi] = mem_data_reg[slot_idx];
    end
  endgenerate

  always_comb begin
    byp_hit_c  = 1'b0;
    byp_data_c = '0;
    if (byp_sel != ZERO_SEL) begin
      if (rf_ld_reg && (rf_sel_reg == byp_sel)) begin
        byp_hit_c  = 1'b1;
        byp_data_c = rf_data_reg;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_hit[i]) begin
          byp_hit_c  = 1'b1;
          byp_data_c = slot_data[i];
        end
      end
    end
  end

  assign byp_hit  = byp_hit_c;
  assign byp_data = byp_data_c;
`endif

endmodule
